// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants used by the fetch stage and its queues.
package riscv_pkg;

  localparam int          XLEN        = 32;
  localparam int          ILEN        = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; used both for fetched instructions and
// for the PCs of requests still waiting on an imem response.
module fetch_queue #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC selection, credit-limited imem issue,
// in-order instruction buffering and redirect flush with stale-response discard.
module fetch_unit #(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter int QDEPTH  = 2,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_next_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            dec_valid_o,
  output logic [31:0]     dec_instr_o,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [XLEN-1:0] dec_pc_plus4_o,
  input  logic            dec_ready_i
);

  localparam int              ILEN = riscv_pkg::ILEN;
  localparam int              QCW  = $clog2(QDEPTH + 1);
  localparam int              OCW  = $clog2(MAX_OUT + 1);
  localparam int              SW   = QCW + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(riscv_pkg::INSTR_BYTES);

  logic [QCW-1:0]       q_count;
  logic                 q_full;
  logic                 q_empty;
  logic [ILEN+XLEN-1:0] q_head;
  logic [OCW-1:0]       inflight;
  logic [OCW-1:0]       discard;
  logic                 pcq_full;
  logic                 pcq_empty;
  logic [XLEN-1:0]      rsp_pc;
  logic [SW-1:0]        occupancy;
  logic                 fire;
  logic                 rsp_take;
  logic                 rsp_keep;
  logic                 pop;

  // Slots already promised: buffered entries plus responses that will still be kept.
  assign occupancy  = SW'(q_count) + SW'(inflight) - SW'(discard);
  assign imem_req_o = rst && !redirect_i && !q_full && !pcq_full
                      && (occupancy < SW'(QDEPTH));
  assign imem_addr_o = pc_i;
  assign fire        = imem_req_o && imem_gnt_i;

  assign pc_next_o = redirect_i ? redirect_pc_i :
                     fire       ? pc_i + STEP   : pc_i;

  assign rsp_take = imem_rvalid_i && !pcq_empty;
  assign rsp_keep = rsp_take && !redirect_i && (discard == '0);
  assign pop      = !q_empty && dec_ready_i;

  // The PC FIFO occupancy doubles as the outstanding-request count.
  fetch_queue #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUT)
  ) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fire),
    .push_data (pc_i),
    .pop       (rsp_take),
    .flush     (1'b0),
    .head      (rsp_pc),
    .count     (inflight),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  fetch_queue #(
    .WIDTH (ILEN + XLEN),
    .DEPTH (QDEPTH)
  ) u_instr_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data ({imem_rdata_i, rsp_pc}),
    .pop       (pop),
    .flush     (redirect_i),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign dec_valid_o    = !q_empty;
  assign dec_instr_o    = q_head[XLEN +: ILEN];
  assign dec_pc_o       = q_head[XLEN-1:0];
  assign dec_pc_plus4_o = dec_pc_o + STEP;

  // On redirect every response still outstanding after this cycle is stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      discard <= '0;
    end else if (redirect_i) begin
      discard <= inflight - OCW'(rsp_take);
    end else if (rsp_take && (discard != '0)) begin
      discard <= discard - 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised self-checking bench for fetch_unit against a queue-based model
// of the fetch stream, an in-order imem with random latency and a pc register.
module tb_fetch_unit;

  localparam int QDEPTH  = 2;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_i;
  logic [31:0] pc_next_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        dec_valid_o;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_pc_plus4_o;
  logic        dec_ready_i;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN    (32),
    .QDEPTH  (QDEPTH),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_i           (pc_i),
    .pc_next_o      (pc_next_o),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .dec_valid_o    (dec_valid_o),
    .dec_instr_o    (dec_instr_o),
    .dec_pc_o       (dec_pc_o),
    .dec_pc_plus4_o (dec_pc_plus4_o),
    .dec_ready_i    (dec_ready_i)
  );

  int checks   = 0;
  int passed   = 0;
  int cyc      = 0;
  int last_due = 0;

  logic [31:0] pc_reg;
  logic [31:0] mq_pc[$];
  logic [31:0] os_addr[$];
  bit          os_stale[$];
  int          os_due[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One fetch cycle: drive at posedge+1, check at negedge, advance the model, wait for the edge.
  task automatic applyStimulus(input bit redir, input logic [31:0] tgt, input bit gnt, input bit rdy);
    bit          rv;
    bit          exp_req;
    bit          exp_fire;
    bit          exp_valid;
    bit          s;
    int          live;
    int          due;
    logic [31:0] exp_next;
    logic [31:0] a;

    rv            = (os_due.size() > 0) && (os_due[0] <= cyc);
    pc_i          = pc_reg;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    imem_gnt_i    = gnt;
    dec_ready_i   = rdy;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(os_addr[0]) : $urandom();
    #4;

    live = 0;
    foreach (os_stale[i]) if (!os_stale[i]) live++;
    exp_req   = !redir && ((mq_pc.size() + live) < QDEPTH) && (os_addr.size() < MAX_OUT);
    exp_fire  = exp_req && gnt;
    exp_next  = redir ? tgt : (exp_fire ? pc_reg + 32'd4 : pc_reg);
    exp_valid = (mq_pc.size() != 0);

    checkOutput("imem_req", 32'(imem_req_o), 32'(exp_req));
    if (exp_req) checkOutput("imem_addr", imem_addr_o, pc_reg);
    checkOutput("pc_next", pc_next_o, exp_next);
    checkOutput("dec_valid", 32'(dec_valid_o), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("dec_pc", dec_pc_o, mq_pc[0]);
      checkOutput("dec_instr", dec_instr_o, mem_word(mq_pc[0]));
      checkOutput("dec_pc_plus4", dec_pc_plus4_o, mq_pc[0] + 32'd4);
    end

    if (exp_valid && rdy) void'(mq_pc.pop_front());
    if (rv) begin
      a = os_addr.pop_front();
      s = os_stale.pop_front();
      void'(os_due.pop_front());
      if (!s && !redir) mq_pc.push_back(a);
    end
    if (redir) begin
      mq_pc.delete();
      foreach (os_stale[i]) os_stale[i] = 1'b1;
    end
    if (exp_fire) begin
      due = cyc + int'($urandom_range(1, 3));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      os_addr.push_back(pc_reg);
      os_stale.push_back(1'b0);
      os_due.push_back(due);
    end
    pc_reg = exp_next;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int hold_cycles);
    imem_gnt_i    = 1'b0;
    redirect_i    = 1'b0;
    dec_ready_i   = 1'b0;
    imem_rvalid_i = 1'b0;
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_req", 32'(imem_req_o), 32'd0);
    checkOutput("rst_valid", 32'(dec_valid_o), 32'd0);
    repeat (hold_cycles) @(posedge clk);
    #1 rst = 1'b1;
    mq_pc.delete();
    os_addr.delete();
    os_stale.delete();
    os_due.delete();
    last_due = cyc;
  endtask

  task automatic randomCycle();
    bit          redir;
    logic [31:0] tgt;
    redir = ($urandom_range(0, 9) == 0);
    case ($urandom_range(0, 3))
      0:       tgt = 32'hFFFF_FFFC;
      1:       tgt = 32'h0000_0100;
      default: tgt = $urandom() & 32'hFFFF_FFFC;
    endcase
    applyStimulus(redir, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pc_reg        = 32'h0;
    pc_i          = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    dec_ready_i   = 1'b0;
    doReset(2);

    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)  applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    for (int i = 0; i < 500; i++) randomCycle();

    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    doReset(3);
    for (int i = 0; i < 40; i++) randomCycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
